// File: rtl/colour_pwm_driver_if.sv
// Bundles the colour request, enable and LED/settled outputs of the colour PWM driver.
// The master is the sequencer side and the slave is the driver.
interface colour_pwm_driver_if;
    logic       enable;
    logic [2:0] colour;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic       settled;

    modport master (output enable, colour, input led_r, led_g, led_b, settled);
    modport slave  (input enable, colour, output led_r, led_g, led_b, settled);
endinterface

// File: rtl/colour_pwm_driver.sv
// Decodes a 3-bit colour into RGB duty targets and cross-fades toward them.
// The ramp moves by one duty step per prescaler tick, and the result drives three PWM pins.
module colour_pwm_driver #(
    parameter int PWM_BITS = 8,
    parameter int MAX_DUTY = 255,
    parameter int STEP_DIV = 1024
) (
    input logic                clk,
    input logic                rst,
    colour_pwm_driver_if.slave bus
);
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] DMAX  = PWM_BITS'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] PLAST = '1;
    localparam logic [SW-1:0]       SLAST = SW'(STEP_DIV - 1);

    typedef enum logic {STEADY, FADING} state_t;

    state_t              r_state, w_state_nx;
    logic [2:0]          r_colour_q;
    logic [PWM_BITS-1:0] r_duty_r, r_duty_g, r_duty_b;
    logic [PWM_BITS-1:0] r_active_r, r_active_g, r_active_b;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [SW-1:0]       r_step_cnt;
    logic                r_led_r, r_led_g, r_led_b, r_settled;

    logic [PWM_BITS-1:0] w_tgt_r, w_tgt_g, w_tgt_b;
    logic                w_match, w_step_tick, w_step_clr;

    function automatic logic [PWM_BITS-1:0] f_approach(input logic [PWM_BITS-1:0] d,
                                                       input logic [PWM_BITS-1:0] t);
        if (d < t)      return d + 1'b1;
        else if (d > t) return d - 1'b1;
        return d;
    endfunction

    always_comb begin
        w_tgt_r     = r_colour_q[0] ? DMAX : '0;
        w_tgt_g     = r_colour_q[1] ? DMAX : '0;
        w_tgt_b     = r_colour_q[2] ? DMAX : '0;
        w_match     = (r_duty_r == w_tgt_r) && (r_duty_g == w_tgt_g) && (r_duty_b == w_tgt_b);
        w_step_tick = (r_step_cnt == SLAST) && bus.enable;
    end

    // With enable low the FSM is frozen, so a pending fade resumes where it stopped.
    always_comb begin
        w_state_nx = r_state;
        w_step_clr = 1'b0;
        if (bus.enable) begin
            case (r_state)
                STEADY: if (!w_match) begin
                    w_state_nx = FADING;
                    w_step_clr = 1'b1;
                end
                FADING: if (w_match) w_state_nx = STEADY;
                default: w_state_nx = STEADY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= STEADY;
            r_settled  <= 1'b1;
            r_colour_q <= '0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_settled  <= (w_state_nx == STEADY);
            r_colour_q <= bus.colour;
            if (w_step_clr)
                r_step_cnt <= '0;
            else if (bus.enable)
                r_step_cnt <= (r_step_cnt == SLAST) ? '0 : r_step_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_duty_r <= '0;
            r_duty_g <= '0;
            r_duty_b <= '0;
        end else if (r_state == FADING && w_step_tick) begin
            r_duty_r <= f_approach(r_duty_r, w_tgt_r);
            r_duty_g <= f_approach(r_duty_g, w_tgt_g);
            r_duty_b <= f_approach(r_duty_b, w_tgt_b);
        end
    end

    // Duties are sampled into active_x only as the counter wraps, so each period uses one duty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm_cnt  <= '0;
            r_active_r <= '0;
            r_active_g <= '0;
            r_active_b <= '0;
            r_led_r    <= 1'b0;
            r_led_g    <= 1'b0;
            r_led_b    <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (r_pwm_cnt == PLAST) begin
                r_active_r <= r_duty_r;
                r_active_g <= r_duty_g;
                r_active_b <= r_duty_b;
            end
            r_led_r <= bus.enable && (r_pwm_cnt < r_active_r);
            r_led_g <= bus.enable && (r_pwm_cnt < r_active_g);
            r_led_b <= bus.enable && (r_pwm_cnt < r_active_b);
        end
    end

    assign bus.led_r   = r_led_r;
    assign bus.led_g   = r_led_g;
    assign bus.led_b   = r_led_b;
    assign bus.settled = r_settled;
endmodule

// File: tb/tb_colour_pwm_driver.sv
// Directed bench for colour_pwm_driver with PWM_BITS=4, MAX_DUTY=15 and STEP_DIV=2.
// It checks reset, ramp timing, retargeting, period-boundary duty updates, enable freeze and async reset.
module tb_colour_pwm_driver;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    colour_pwm_driver_if bus ();

    colour_pwm_driver #(.PWM_BITS(4), .MAX_DUTY(15), .STEP_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic count16(output int hr, output int hg, output int hb);
        hr = 0; hg = 0; hb = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            hr += int'(bus.led_r);
            hg += int'(bus.led_g);
            hb += int'(bus.led_b);
        end
    endtask

    // Red duty n clocks after a 0->1 colour change from a settled dark state.
    function automatic int ramp_up(input int n);
        if (n < 2) return 0;
        return ((n - 2) / 2 > 15) ? 15 : (n - 2) / 2;
    endfunction

    initial begin
        int hr, hg, hb, acc, sacc, n;
        bit found;

        bus.enable = 1'b1;
        bus.colour = 3'd0;
        rst = 1'b1;
        #2 rst = 1'b0;
        tick(3);
        chk("rst_led_r", bus.led_r, 0);
        chk("rst_led_g", bus.led_g, 0);
        chk("rst_led_b", bus.led_b, 0);
        chk("rst_settled", bus.settled, 1);
        chk("rst_duty_r", dut.r_duty_r, 0);
        chk("rst_pwm_cnt", dut.r_pwm_cnt, 0);
        rst = 1'b1;

        // dark and idle after release
        acc = 0; sacc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            acc  += int'(bus.led_r) + int'(bus.led_g) + int'(bus.led_b);
            sacc += int'(!bus.settled);
        end
        chk("idle_led_highs", acc, 0);
        chk("idle_unsettled", sacc, 0);
        chk("idle_duty_r", dut.r_duty_r, 0);

        // ramp red up
        bus.colour = 3'd1;
        tick();
        chk("up_settled_1clk", bus.settled, 1);
        tick();
        chk("up_settled_2clk", bus.settled, 0);
        tick(14);
        chk("up_duty_r_mid", dut.r_duty_r, 7);
        chk("up_duty_g_mid", dut.r_duty_g, 0);
        tick(16);
        chk("up_duty_r_end", dut.r_duty_r, 15);
        chk("up_settled_end", bus.settled, 0);
        tick();
        chk("up_settled_after", bus.settled, 1);
        tick(40);
        count16(hr, hg, hb);
        chk("red_highs", hr, 15);
        chk("red_g_highs", hg, 0);
        chk("red_b_highs", hb, 0);

        // white, then blue only
        bus.colour = 3'd7;
        tick(40);
        chk("white_duty_g", dut.r_duty_g, 15);
        chk("white_duty_b", dut.r_duty_b, 15);
        chk("white_settled", bus.settled, 1);
        bus.colour = 3'd4;
        tick(12);
        chk("blue_duty_r_mid", dut.r_duty_r, 10);
        chk("blue_duty_g_mid", dut.r_duty_g, 10);
        chk("blue_duty_b_mid", dut.r_duty_b, 15);
        chk("blue_settled_mid", bus.settled, 0);
        tick(30);
        chk("blue_settled", bus.settled, 1);
        chk("blue_duty_r", dut.r_duty_r, 0);
        count16(hr, hg, hb);
        chk("blue_r_highs", hr, 0);
        chk("blue_g_highs", hg, 0);
        chk("blue_b_highs", hb, 15);

        // retarget mid-fade
        bus.colour = 3'd0;
        tick(40);
        chk("dark_duty_b", dut.r_duty_b, 0);
        bus.colour = 3'd1;
        tick(14);
        chk("rt_duty_r_peak", dut.r_duty_r, 6);
        bus.colour = 3'd0;
        tick();
        chk("rt_no_jump", dut.r_duty_r, 6);
        tick();
        chk("rt_first_down", dut.r_duty_r, 5);
        tick(10);
        chk("rt_duty_r_zero", dut.r_duty_r, 0);
        chk("rt_settled_pre", bus.settled, 0);
        tick();
        chk("rt_settled", bus.settled, 1);

        // every PWM period of a ramp carries a single duty
        tick(10);
        bus.colour = 3'd1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            n++;
            if (n >= 4 && dut.r_pwm_cnt == 4'd0) found = 1'b1;
        end
        chk("align_found", int'(found), 1);
        for (int p = 0; p < 2; p++) begin
            int exp_h;
            exp_h = ramp_up(n - 1);
            count16(hr, hg, hb);
            n += 16;
            chk("period_highs", hr, exp_h);
        end

        // enable freeze mid-fade
        bus.colour = 3'd0;
        tick(45);
        chk("pre_en_duty_r", dut.r_duty_r, 0);
        bus.colour = 3'd1;
        tick(20);
        chk("en_duty_r_9", dut.r_duty_r, 9);
        bus.enable = 1'b0;
        tick();
        chk("en_off_led_r", bus.led_r, 0);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            acc += int'(bus.led_r) + int'(bus.led_g) + int'(bus.led_b);
        end
        chk("en_off_highs", acc, 0);
        chk("en_off_duty_hold", dut.r_duty_r, 9);
        chk("en_off_settled", bus.settled, 0);
        bus.enable = 1'b1;
        tick(2);
        chk("en_resume_10", dut.r_duty_r, 10);
        tick(10);
        chk("en_resume_15", dut.r_duty_r, 15);
        chk("en_resume_unsettled", bus.settled, 0);
        tick();
        chk("en_resume_settled", bus.settled, 1);

        // asynchronous reset mid-fade
        tick(40);
        bus.colour = 3'd0;
        tick(10);
        chk("ar_duty_r_mid", dut.r_duty_r, 11);
        #1 rst = 1'b0;
        #1;
        chk("ar_led_r", bus.led_r, 0);
        chk("ar_settled", bus.settled, 1);
        chk("ar_duty_r", dut.r_duty_r, 0);
        tick(3);
        chk("ar_hold_duty_r", dut.r_duty_r, 0);
        rst = 1'b1;
        tick(10);
        chk("ar_after_settled", bus.settled, 1);
        chk("ar_after_duty_r", dut.r_duty_r, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
